apb_seq_master: RTL and testbench

APB_SEQ_MASTER -- requirements
Module: apb_seq_master

---
 rtl/apb_seq_pkg.sv | 36 +++
 rtl/sync_fifo.sv | 50 +++++
 rtl/apb_seq_master.sv | 140 ++++++++++++++
 tb/tb_apb_seq_master.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_seq_pkg.sv
// Shared types and width helpers for the APB sequencing master.
// Holds the FSM state encoding, the command record and the derived-width functions.
package apb_seq_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int DEPTH_DEF   = 16;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Command record at the default widths; the top uses the same field order for its own widths.
  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } cmd_t;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int wait_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  function automatic int cmd_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with extra-bit pointers.
// A push while full is dropped; a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign level    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[PTR_W-1:0]];

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/apb_seq_master.sv
// APB requester that drains a command FIFO one transfer at a time and
// returns one response per command, with a bounded wait for PREADY.
module apb_seq_master
  import apb_seq_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [ADDR_W-1:0]           cmd_addr,
  input  logic [DATA_W-1:0]           cmd_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_write,
  output logic                        rsp_timeout,
  output logic                        PSELx,
  output logic                        PENABLE,
  output logic                        PWRITE,
  output logic [ADDR_W-1:0]           PADDR,
  output logic [DATA_W-1:0]           PWDATA,
  input  logic [DATA_W-1:0]           PRDATA,
  input  logic                        PREADY,
  output logic                        busy,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int CMD_W  = cmd_w(ADDR_W, DATA_W);
  localparam int WAIT_W = wait_w(TIMEOUT);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_rec_t;

  state_t           state;
  state_t           state_nxt;
  cmd_rec_t         push_cmd;
  cmd_rec_t         head_cmd;
  logic [CMD_W-1:0] head_bits;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             timeout_hit;
  logic             done;
  logic [WAIT_W-1:0] wait_cnt;

  assign push_cmd    = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign head_cmd    = cmd_rec_t'(head_bits);
  assign cmd_ready   = !full && !PRESET;
  assign push        = cmd_valid && cmd_ready;
  assign pop         = (state == IDLE) && !empty;
  assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT));
  assign done        = (state == ACCESS) && (PREADY || timeout_hit);
  assign busy        = !empty || (state != IDLE);

  sync_fifo #(
    .WIDTH(CMD_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (PCLK),
    .rst      (PRESET),
    .push     (push),
    .push_data(push_cmd),
    .pop      (pop),
    .pop_data (head_bits),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!empty)    state_nxt = SETUP;
      SETUP:                  state_nxt = ACCESS;
      ACCESS:  if (done)      state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    PSELx     = 1'b0;
    PENABLE   = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      SETUP:   PSELx = 1'b1;
      ACCESS:  begin PSELx = 1'b1; PENABLE = 1'b1; end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Counts SETUP plus ACCESS cycles, so its value equals the current ACCESS cycle number.
  always_ff @(posedge PCLK) begin
    if (PRESET || pop) begin
      wait_cnt <= '0;
    end else if ((state == SETUP || state == ACCESS) && !timeout_hit) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      rsp_rdata   <= '0;
      rsp_write   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (pop) begin
        PADDR  <= head_cmd.addr;
        PWRITE <= head_cmd.write;
        PWDATA <= head_cmd.wdata;
      end
      if (done) begin
        rsp_write   <= PWRITE;
        rsp_timeout <= !PREADY;
        rsp_rdata   <= (PREADY && !PWRITE) ? PRDATA : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_seq_master.sv
// Directed bench for apb_seq_master (DEPTH=4, TIMEOUT=8) with hand-computed
// expectations checked by immediate assertions at fixed cycle points.
module tb_apb_seq_master;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic              PCLK;
  logic              PRESET;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_write;
  logic              rsp_timeout;
  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              busy;
  logic [2:0]        level;

  int checks = 0;
  int errors = 0;

  apb_seq_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_write  (rsp_write),
    .rsp_timeout(rsp_timeout),
    .PSELx      (PSELx),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .busy       (busy),
    .level      (level)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic drive_cmd(input logic w, input logic [7:0] a, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  logic       saw_activity;
  logic [7:0] seen [3];
  logic [7:0] order_exp [3];
  int         got;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    order_exp[0] = 8'h01;
    order_exp[1] = 8'h02;
    order_exp[2] = 8'h03;

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0;
    tick(); tick(); tick();

    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_psel",      32'(PSELx), 0);
    check("rst_penable",   32'(PENABLE), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_level",     32'(level), 0);
    check("rst_paddr",     32'(PADDR), 0);
    check("rst_pwrite",    32'(PWRITE), 0);
    check("rst_pwdata",    32'(PWDATA), 0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 0);
    check("rst_rsp_write", 32'(rsp_write), 0);
    check("rst_rsp_tmo",   32'(rsp_timeout), 0);
    PRESET = 1'b0;
    tick();
    check("post_rst_cmd_ready", 32'(cmd_ready), 1);

    // Two writes with PREADY high
    PRDATA = 8'h33; PREADY = 1'b1; rsp_ready = 1'b1;
    drive_cmd(1'b1, 8'h20, 8'h04); tick();
    check("t1_level_push", 32'(level), 1);
    check("t1_busy",       32'(busy), 1);
    drive_cmd(1'b1, 8'h40, 8'hF0); tick();
    cmd_valid = 1'b0;
    check("t1_setup_psel",   32'(PSELx), 1);
    check("t1_setup_pen",    32'(PENABLE), 0);
    check("t1_setup_paddr",  32'(PADDR), 'h20);
    check("t1_setup_pwrite", 32'(PWRITE), 1);
    check("t1_setup_pwdata", 32'(PWDATA), 'h04);
    check("t1_level_pushpop", 32'(level), 1);
    tick();
    check("t1_access_psel",  32'(PSELx), 1);
    check("t1_access_pen",   32'(PENABLE), 1);
    check("t1_access_paddr", 32'(PADDR), 'h20);
    tick();
    check("t1_resp_valid", 32'(rsp_valid), 1);
    check("t1_resp_write", 32'(rsp_write), 1);
    check("t1_resp_tmo",   32'(rsp_timeout), 0);
    check("t1_resp_rdata", 32'(rsp_rdata), 0);
    check("t1_resp_psel",  32'(PSELx), 0);
    check("t1_resp_pen",   32'(PENABLE), 0);
    tick();
    check("t1_idle_valid", 32'(rsp_valid), 0);
    check("t1_idle_psel",  32'(PSELx), 0);
    tick();
    check("t1_setup2_psel",   32'(PSELx), 1);
    check("t1_setup2_pen",    32'(PENABLE), 0);
    check("t1_setup2_paddr",  32'(PADDR), 'h40);
    check("t1_setup2_pwdata", 32'(PWDATA), 'hF0);
    check("t1_setup2_level",  32'(level), 0);
    tick();
    check("t1_access2_pen", 32'(PENABLE), 1);
    tick();
    check("t1_resp2_valid", 32'(rsp_valid), 1);
    check("t1_resp2_write", 32'(rsp_write), 1);
    check("t1_resp2_tmo",   32'(rsp_timeout), 0);
    tick();
    check("t1_done_busy",   32'(busy), 0);
    check("t1_hold_paddr",  32'(PADDR), 'h40);
    check("t1_hold_pwdata", 32'(PWDATA), 'hF0);

    // Read with three wait states
    PREADY = 1'b0; PRDATA = 8'hA5;
    drive_cmd(1'b0, 8'h60, 8'h00); tick();
    cmd_valid = 1'b0;
    tick();
    check("t2_setup_paddr",  32'(PADDR), 'h60);
    check("t2_setup_pwrite", 32'(PWRITE), 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_access%0d_pen", i),   32'(PENABLE), 1);
      check($sformatf("t2_access%0d_paddr", i), 32'(PADDR), 'h60);
      PREADY = (i == 3);
      tick();
    end
    check("t2_resp_valid", 32'(rsp_valid), 1);
    check("t2_resp_rdata", 32'(rsp_rdata), 'hA5);
    check("t2_resp_write", 32'(rsp_write), 0);
    check("t2_resp_tmo",   32'(rsp_timeout), 0);
    check("t2_resp_psel",  32'(PSELx), 0);
    tick();

    // Timeout after 8 ACCESS cycles, then the queued write proceeds
    PREADY = 1'b0;
    drive_cmd(1'b0, 8'h70, 8'h00); tick();
    drive_cmd(1'b1, 8'h71, 8'h55); tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_access%0d_pen", i), 32'(PENABLE), 1);
      tick();
    end
    check("t3_resp_valid", 32'(rsp_valid), 1);
    check("t3_resp_tmo",   32'(rsp_timeout), 1);
    check("t3_resp_rdata", 32'(rsp_rdata), 0);
    check("t3_resp_psel",  32'(PSELx), 0);
    check("t3_resp_pen",   32'(PENABLE), 0);
    check("t3_level_kept", 32'(level), 1);
    PREADY = 1'b1;
    tick();
    tick();
    check("t3_next_psel",   32'(PSELx), 1);
    check("t3_next_paddr",  32'(PADDR), 'h71);
    check("t3_next_pwrite", 32'(PWRITE), 1);
    tick();
    tick();
    check("t3_next_valid", 32'(rsp_valid), 1);
    check("t3_next_tmo",   32'(rsp_timeout), 0);
    check("t3_next_write", 32'(rsp_write), 1);
    tick();

    // Fill: one in flight plus four queued, sixth push refused
    rsp_ready = 1'b0; PREADY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_cmd(1'b1, 8'(8'h80 + i), 8'(i));
      check($sformatf("t4_ready_before_push%0d", i + 1), 32'(cmd_ready), (i < 5) ? 1 : 0);
      tick();
    end
    cmd_valid = 1'b0;
    check("t4_level_full", 32'(level), 4);
    check("t4_ready_full", 32'(cmd_ready), 0);
    check("t4_rsp_held",   32'(rsp_valid), 1);

    PRESET = 1'b1; tick();
    PRESET = 1'b0; tick();
    check("t4_reset_level", 32'(level), 0);

    // Reset pulsed mid-ACCESS with three commands queued
    rsp_ready = 1'b1; PREADY = 1'b0;
    drive_cmd(1'b0, 8'hC0, 8'h00); tick();
    drive_cmd(1'b0, 8'hC1, 8'h00); tick();
    drive_cmd(1'b0, 8'hC2, 8'h00); tick();
    drive_cmd(1'b0, 8'hC3, 8'h00); tick();
    cmd_valid = 1'b0;
    check("t5_in_access", 32'(PENABLE), 1);
    check("t5_queued",    32'(level), 3);
    PRESET = 1'b1; tick();
    check("t5_psel_drop",  32'(PSELx), 0);
    check("t5_level_zero", 32'(level), 0);
    check("t5_ready_rst",  32'(cmd_ready), 0);
    check("t5_busy_zero",  32'(busy), 0);
    PRESET = 1'b0; PREADY = 1'b1;
    saw_activity = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (rsp_valid || PSELx) saw_activity = 1'b1;
    end
    check("t5_no_response", 32'(saw_activity), 0);

    // Push and pop together at level 2; FIFO order preserved
    rsp_ready = 1'b0; PREADY = 1'b1;
    drive_cmd(1'b1, 8'h0F, 8'h00); tick();
    drive_cmd(1'b1, 8'h01, 8'h11); tick();
    drive_cmd(1'b1, 8'h02, 8'h22); tick();
    cmd_valid = 1'b0;
    tick();
    check("t6_held_resp", 32'(rsp_valid), 1);
    check("t6_level_two", 32'(level), 2);
    rsp_ready = 1'b1;
    tick();
    check("t6_idle_level", 32'(level), 2);
    drive_cmd(1'b1, 8'h03, 8'h33); tick();
    cmd_valid = 1'b0;
    check("t6_pushpop_level", 32'(level), 2);
    check("t6_first_setup",   32'(PSELx && !PENABLE), 1);
    seen[0] = PADDR;
    got = 1;
    for (int i = 0; i < 40 && got < 3; i++) begin
      tick();
      if (PSELx && !PENABLE) begin
        seen[got] = PADDR;
        got++;
      end
    end
    check("t6_order_count", 32'(got), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t6_order%0d", i), 32'(seen[i]), 32'(order_exp[i]));
    end
    tick(); tick(); tick();
    check("t6_final_busy",  32'(busy), 0);
    check("t6_final_level", 32'(level), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
